// File: rtl/int_issue_queue.sv
// Integer issue queue: oldest-ready select via age matrix,
// writeback tag wakeup with dispatch bypass, full flush.
module int_issue_queue #(
  parameter int IQ_DEPTH       = 8,
  parameter int DISPATCH_WIDTH = 2,
  parameter int WB_PORTS       = 2,
  parameter int PREG_W         = 6,
  parameter int ROB_IDX_W      = 6,
  parameter int PAYLOAD_W      = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic [DISPATCH_WIDTH-1:0]           disp_valid_i,
  output logic                                disp_ready_o,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0]    disp_psrc0_i,
  input  logic [DISPATCH_WIDTH-1:0]           disp_src0_rdy_i,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0]    disp_psrc1_i,
  input  logic [DISPATCH_WIDTH-1:0]           disp_src1_rdy_i,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0]    disp_pdst_i,
  input  logic [DISPATCH_WIDTH*ROB_IDX_W-1:0] disp_rob_idx_i,
  input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] disp_payload_i,
  input  logic [WB_PORTS-1:0]                 wb_valid_i,
  input  logic [WB_PORTS*PREG_W-1:0]          wb_pdst_i,
  output logic                                issue_valid_o,
  input  logic                                issue_ready_i,
  output logic [PREG_W-1:0]                   issue_psrc0_o,
  output logic [PREG_W-1:0]                   issue_psrc1_o,
  output logic [PREG_W-1:0]                   issue_pdst_o,
  output logic [ROB_IDX_W-1:0]                issue_rob_idx_o,
  output logic [PAYLOAD_W-1:0]                issue_payload_o,
  output logic [$clog2(IQ_DEPTH+1)-1:0]       free_cnt_o
);

  localparam int CNT_W  = $clog2(IQ_DEPTH + 1);
  localparam int IDX_W  = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int LANE_W = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  logic [IQ_DEPTH-1:0] valid, s0_rdy, s1_rdy;
  logic [PREG_W-1:0]    psrc0   [IQ_DEPTH];
  logic [PREG_W-1:0]    psrc1   [IQ_DEPTH];
  logic [PREG_W-1:0]    pdst    [IQ_DEPTH];
  logic [ROB_IDX_W-1:0] rob_idx [IQ_DEPTH];
  logic [PAYLOAD_W-1:0] payload [IQ_DEPTH];
  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] age, age_nxt;
  logic [CNT_W-1:0] free_cnt;
  logic             stall;
  logic [IDX_W-1:0] stall_idx;

  logic [PREG_W-1:0]    l_psrc0   [DISPATCH_WIDTH];
  logic [PREG_W-1:0]    l_psrc1   [DISPATCH_WIDTH];
  logic [PREG_W-1:0]    l_pdst    [DISPATCH_WIDTH];
  logic [ROB_IDX_W-1:0] l_rob_idx [DISPATCH_WIDTH];
  logic [PAYLOAD_W-1:0] l_payload [DISPATCH_WIDTH];
  logic [DISPATCH_WIDTH-1:0] l_rdy0, l_rdy1, accept;

  logic [IQ_DEPTH-1:0] wk0, wk1, alloc, cand, oldest;
  logic [LANE_W-1:0]   alloc_lane [IQ_DEPTH];
  logic [CNT_W-1:0]    n_acc, free_nxt;
  logic [IDX_W-1:0]    sel;
  logic                fire;

  assign disp_ready_o = !rst && !flush_i &&
                        (free_cnt >= CNT_W'(DISPATCH_WIDTH));

  // Lane unpack with same-cycle writeback bypass
  always_comb begin
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      l_psrc0[k]   = disp_psrc0_i[k*PREG_W +: PREG_W];
      l_psrc1[k]   = disp_psrc1_i[k*PREG_W +: PREG_W];
      l_pdst[k]    = disp_pdst_i[k*PREG_W +: PREG_W];
      l_rob_idx[k] = disp_rob_idx_i[k*ROB_IDX_W +: ROB_IDX_W];
      l_payload[k] = disp_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
      l_rdy0[k]    = disp_src0_rdy_i[k];
      l_rdy1[k]    = disp_src1_rdy_i[k];
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid_i[p] && wb_pdst_i[p*PREG_W +: PREG_W] == l_psrc0[k])
          l_rdy0[k] = 1'b1;
        if (wb_valid_i[p] && wb_pdst_i[p*PREG_W +: PREG_W] == l_psrc1[k])
          l_rdy1[k] = 1'b1;
      end
    end
  end

  always_comb begin
    wk0 = '0;
    wk1 = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid_i[p] && wb_pdst_i[p*PREG_W +: PREG_W] == psrc0[i])
          wk0[i] = 1'b1;
        if (wb_valid_i[p] && wb_pdst_i[p*PREG_W +: PREG_W] == psrc1[i])
          wk1[i] = 1'b1;
      end
    end
  end

  // k-th accepted lane takes the k-th lowest free entry
  always_comb begin
    int rank [DISPATCH_WIDTH];
    int cnt;
    int frank;
    accept = disp_valid_i & {DISPATCH_WIDTH{disp_ready_o}};
    cnt = 0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      rank[k] = cnt;
      if (accept[k]) cnt = cnt + 1;
    end
    n_acc = CNT_W'(cnt);
    alloc = '0;
    frank = 0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      alloc_lane[i] = '0;
      if (!valid[i]) begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
          if (accept[k] && rank[k] == frank) begin
            alloc[i]      = 1'b1;
            alloc_lane[i] = LANE_W'(k);
          end
        end
        frank = frank + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      for (int j = 0; j < IQ_DEPTH; j++) begin
        if (alloc[i] && alloc[j])
          age_nxt[i][j] = alloc_lane[i] < alloc_lane[j];
        else if (alloc[i])
          age_nxt[i][j] = 1'b0;
        else if (alloc[j])
          age_nxt[i][j] = 1'b1;
        else
          age_nxt[i][j] = age[i][j];
      end
    end
  end

  // A stalled pick stays locked even if an older entry wakes meanwhile
  always_comb begin
    cand = valid & s0_rdy & s1_rdy;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      oldest[i] = cand[i];
      for (int j = 0; j < IQ_DEPTH; j++) begin
        if (j != i && cand[j] && age[j][i]) oldest[i] = 1'b0;
      end
    end
    sel = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (oldest[i]) sel = IDX_W'(i);
    end
    if (stall && cand[stall_idx]) sel = stall_idx;
  end

  assign issue_valid_o   = (|cand) && !flush_i && !rst;
  assign fire            = issue_valid_o && issue_ready_i;
  assign free_nxt        = free_cnt + CNT_W'(fire) - n_acc;
  assign issue_psrc0_o   = psrc0[sel];
  assign issue_psrc1_o   = psrc1[sel];
  assign issue_pdst_o    = pdst[sel];
  assign issue_rob_idx_o = rob_idx[sel];
  assign issue_payload_o = payload[sel];
  assign free_cnt_o      = free_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      s0_rdy    <= '0;
      s1_rdy    <= '0;
      age       <= '0;
      free_cnt  <= CNT_W'(IQ_DEPTH);
      stall     <= 1'b0;
      stall_idx <= '0;
    end else if (flush_i) begin
      valid    <= '0;
      free_cnt <= CNT_W'(IQ_DEPTH);
      stall    <= 1'b0;
    end else begin
      free_cnt  <= free_nxt;
      stall     <= issue_valid_o && !issue_ready_i;
      stall_idx <= sel;
      age       <= age_nxt;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        if (alloc[i]) begin
          valid[i]   <= 1'b1;
          s0_rdy[i]  <= l_rdy0[alloc_lane[i]];
          s1_rdy[i]  <= l_rdy1[alloc_lane[i]];
          psrc0[i]   <= l_psrc0[alloc_lane[i]];
          psrc1[i]   <= l_psrc1[alloc_lane[i]];
          pdst[i]    <= l_pdst[alloc_lane[i]];
          rob_idx[i] <= l_rob_idx[alloc_lane[i]];
          payload[i] <= l_payload[alloc_lane[i]];
        end else begin
          if (fire && sel == IDX_W'(i)) valid[i] <= 1'b0;
          if (wk0[i]) s0_rdy[i] <= 1'b1;
          if (wk1[i]) s1_rdy[i] <= 1'b1;
        end
      end
    end
  end

endmodule
